// File: rtl/watch_mode_ctrl_pkg.sv
// Shared definitions for the watch mode controller: the 3-bit mode encoding seen by the
// display block and time counters, plus small mode-class helpers.
package watch_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    S_STOPWATCH_HIDE_STOPPED = 3'b000,
    S_STOPWATCH_SET_H        = 3'b001,
    S_STOPWATCH_SET_M        = 3'b010,
    S_STOPWATCH_SHOW_STOPPED = 3'b011,
    S_STOPWATCH_SHOW_RUNNING = 3'b100,
    S_STOPWATCH_SW_RESET     = 3'b101,
    S_STOPWATCH_HIDE_RUNNING = 3'b110
  } state_e;

  // Debounced button events after M > A > B arbitration; at most one bit set.
  typedef struct packed {
    logic m;
    logic a;
    logic b;
  } btn_sel_t;

  function automatic logic is_run_state(state_e s);
    return (s == S_STOPWATCH_SHOW_RUNNING) || (s == S_STOPWATCH_HIDE_RUNNING);
  endfunction

  function automatic logic is_set_state(state_e s);
    return (s == S_STOPWATCH_SET_H) || (s == S_STOPWATCH_SET_M);
  endfunction

  function automatic btn_sel_t arbitrate(logic ev_m, logic ev_a, logic ev_b);
    btn_sel_t sel;
    sel.m = ev_m;
    sel.a = ev_a & ~ev_m;
    sel.b = ev_b & ~ev_m & ~ev_a;
    return sel;
  endfunction

endpackage

// File: rtl/watch_mode_ctrl_if.sv
// User-facing bundle of the watch mode controller: seconds tick, raw buttons, mode bus and
// the control pulses going to the timekeeping and stopwatch counters.
interface watch_mode_ctrl_if;

  logic       seconds_clk;
  logic       btn_mode;
  logic       btn_a;
  logic       btn_b;
  logic [2:0] state;
  logic       sw_run;
  logic       sw_clear;
  logic       inc_h;
  logic       inc_m;

  modport master (
    output seconds_clk,
    output btn_mode,
    output btn_a,
    output btn_b,
    input  state,
    input  sw_run,
    input  sw_clear,
    input  inc_h,
    input  inc_m
  );

  modport slave (
    input  seconds_clk,
    input  btn_mode,
    input  btn_a,
    input  btn_b,
    output state,
    output sw_run,
    output sw_clear,
    output inc_h,
    output inc_m
  );

endinterface

// File: rtl/watch_mode_ctrl_btn_debounce.sv
// Single-button debouncer: 2-FF synchroniser, stability counter, accepted level and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned DEB_W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);

  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] cnt_d, cnt_q;
  logic             stable_d, stable_q;
  logic             rise_d, rise_q;
  logic             arm_d, arm_q;

  // Synchroniser is free-running so a button held across reset is still seen as held.
  always_ff @(posedge clk_i) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    // A press is only reported once the button has been seen released since reset.
    arm_d    = arm_q | ~sync2_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
        rise_d   = sync2_q & arm_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      arm_q    <= arm_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch mode controller: debounces M/A/B, runs the mode FSM with set-mode idle timeout on
// the 1 Hz tick, and issues registered control pulses to the counters.
module watch_mode_ctrl
  import watch_mode_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned DEB_W      = 16,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input  logic            clk,
  input  logic            reset,
  watch_mode_ctrl_if.slave bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_S + 1);

  logic ev_m, ev_a, ev_b;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W     (DEB_W)
  ) u_deb_mode (
    .clk_i (clk),
    .rst_ni(reset),
    .btn_i (bus.btn_mode),
    .rise_o(ev_m)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W     (DEB_W)
  ) u_deb_a (
    .clk_i (clk),
    .rst_ni(reset),
    .btn_i (bus.btn_a),
    .rise_o(ev_a)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .DEB_W     (DEB_W)
  ) u_deb_b (
    .clk_i (clk),
    .rst_ni(reset),
    .btn_i (bus.btn_b),
    .rise_o(ev_b)
  );

  state_e          state_d, state_q;
  logic [TO_W-1:0] to_cnt_d, to_cnt_q;
  logic            sec_q;
  logic            sw_run_d, sw_run_q;
  logic            sw_clear_d, sw_clear_q;
  logic            inc_h_d, inc_h_q;
  logic            inc_m_d, inc_m_q;
  logic            sec_rise;
  logic            any_ev;
  logic            timeout_hit;
  btn_sel_t        sel;

  always_comb begin
    sel         = arbitrate(ev_m, ev_a, ev_b);
    any_ev      = ev_m | ev_a | ev_b;
    sec_rise    = bus.seconds_clk & ~sec_q;
    timeout_hit = sec_rise && (to_cnt_q == TO_W'(TIMEOUT_S - 1));

    state_d  = state_q;
    to_cnt_d = '0;
    inc_h_d  = 1'b0;
    inc_m_d  = 1'b0;

    // Any button event in a set mode restarts the idle count and beats a same-cycle timeout.
    if (is_set_state(state_q) && !any_ev && !timeout_hit) begin
      to_cnt_d = sec_rise ? to_cnt_q + TO_W'(1) : to_cnt_q;
    end

    case (state_q)
      S_STOPWATCH_HIDE_STOPPED: begin
        if (sel.m)      state_d = S_STOPWATCH_SET_H;
        else if (sel.a) state_d = S_STOPWATCH_SHOW_STOPPED;
      end
      S_STOPWATCH_SET_H: begin
        if (sel.m)            state_d = S_STOPWATCH_SET_M;
        else if (sel.b)       inc_h_d = 1'b1;
        else if (!any_ev && timeout_hit) state_d = S_STOPWATCH_HIDE_STOPPED;
      end
      S_STOPWATCH_SET_M: begin
        if (sel.m)            state_d = S_STOPWATCH_HIDE_STOPPED;
        else if (sel.b)       inc_m_d = 1'b1;
        else if (!any_ev && timeout_hit) state_d = S_STOPWATCH_HIDE_STOPPED;
      end
      S_STOPWATCH_SHOW_STOPPED: begin
        if (sel.m)      state_d = S_STOPWATCH_HIDE_STOPPED;
        else if (sel.a) state_d = S_STOPWATCH_SHOW_RUNNING;
        else if (sel.b) state_d = S_STOPWATCH_SW_RESET;
      end
      S_STOPWATCH_SHOW_RUNNING: begin
        if (sel.m)      state_d = S_STOPWATCH_HIDE_RUNNING;
        else if (sel.a) state_d = S_STOPWATCH_SHOW_STOPPED;
      end
      S_STOPWATCH_SW_RESET: begin
        state_d = S_STOPWATCH_SHOW_STOPPED;
      end
      S_STOPWATCH_HIDE_RUNNING: begin
        if (sel.m || sel.a) state_d = S_STOPWATCH_SHOW_RUNNING;
      end
      default: begin
        state_d = S_STOPWATCH_HIDE_STOPPED;
      end
    endcase

    sw_run_d   = is_run_state(state_d);
    sw_clear_d = (state_d == S_STOPWATCH_SW_RESET);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_STOPWATCH_HIDE_STOPPED;
      to_cnt_q   <= '0;
      sec_q      <= 1'b0;
      sw_run_q   <= 1'b0;
      sw_clear_q <= 1'b0;
      inc_h_q    <= 1'b0;
      inc_m_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      sec_q      <= bus.seconds_clk;
      sw_run_q   <= sw_run_d;
      sw_clear_q <= sw_clear_d;
      inc_h_q    <= inc_h_d;
      inc_m_q    <= inc_m_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.sw_run   = sw_run_q;
  assign bus.sw_clear = sw_clear_q;
  assign bus.inc_h    = inc_h_q;
  assign bus.inc_m    = inc_m_q;

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Randomized bench for watch_mode_ctrl: button/second actions checked against a table-driven
// mode model and pulse counts gathered by a negedge monitor.
module tb_watch_mode_ctrl;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned TimeoutS  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  watch_mode_ctrl_if bus ();

  watch_mode_ctrl #(
    .DEB_CYCLES(DebCycles),
    .DEB_W     (4),
    .TIMEOUT_S (TimeoutS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse/cycle tallies sampled mid-cycle.
  int mon_inc_h = 0, mon_inc_m = 0, mon_clr = 0, mon_swr = 0, mon_clr_swr = 0;
  always @(negedge clk) begin
    if (bus.inc_h) mon_inc_h++;
    if (bus.inc_m) mon_inc_m++;
    if (bus.sw_clear) mon_clr++;
    if (bus.state == 3'b101) mon_swr++;
    if (bus.sw_clear && bus.state == 3'b101) mon_clr_swr++;
  end

  int s_h, s_m, s_c, s_w, s_cw;

  // Reference: mode after an event [mode][0=M,1=A,2=B]; idle seconds counted in set modes.
  int nxt[7][3];
  int m_st, m_to;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mask);
    bus.btn_mode = mask[2];
    bus.btn_a    = mask[1];
    bus.btn_b    = mask[0];
  endtask

  task automatic snap();
    s_h = mon_inc_h; s_m = mon_inc_m; s_c = mon_clr; s_w = mon_swr; s_cw = mon_clr_swr;
  endtask

  task automatic check_outputs(input string tag, input int eh, input int em, input int ec);
    check_val({tag, " state"}, int'(bus.state), m_st);
    check_val({tag, " sw_run"}, int'(bus.sw_run), (m_st == 4 || m_st == 6) ? 1 : 0);
    check_val({tag, " inc_h pulses"}, mon_inc_h - s_h, eh);
    check_val({tag, " inc_m pulses"}, mon_inc_m - s_m, em);
    check_val({tag, " sw_clear cycles"}, mon_clr - s_c, ec);
    check_val({tag, " sw_reset cycles"}, mon_swr - s_w, ec);
    check_val({tag, " clear in sw_reset"}, mon_clr_swr - s_cw, ec);
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input bit bounce);
    int ev;
    int eh, em, ec;
    eh = 0; em = 0; ec = 0;
    snap();
    if (bounce) begin
      drive(mask); tick();
      drive(3'b000); tick();
    end
    drive(mask);
    repeat (hold) tick();
    drive(3'b000);
    repeat (12) tick();
    ev = mask[2] ? 0 : mask[1] ? 1 : mask[0] ? 2 : -1;
    if (ev >= 0) begin
      if (ev == 2 && m_st == 1) eh = 1;
      if (ev == 2 && m_st == 2) em = 1;
      if (ev == 2 && m_st == 3) ec = 1;
      m_st = nxt[m_st][ev];
      m_to = 0;
    end
    check_outputs(bounce ? "bounce" : "press", eh, em, ec);
  endtask

  task automatic glitch(input logic [2:0] mask, input int len);
    snap();
    drive(mask);
    repeat (len) tick();
    drive(3'b000);
    repeat (10) tick();
    check_outputs("glitch", 0, 0, 0);
  endtask

  task automatic second();
    snap();
    bus.seconds_clk = 1'b1;
    repeat (3) tick();
    bus.seconds_clk = 1'b0;
    repeat (3) tick();
    if (m_st == 1 || m_st == 2) begin
      m_to++;
      if (m_to == int'(TimeoutS)) begin
        m_st = 0;
        m_to = 0;
      end
    end
    check_outputs("second", 0, 0, 0);
  endtask

  initial begin
    logic [2:0] mask;
    int r;

    nxt[0] = '{1, 3, 0};
    nxt[1] = '{2, 1, 1};
    nxt[2] = '{0, 2, 2};
    nxt[3] = '{0, 4, 3};
    nxt[4] = '{6, 3, 4};
    nxt[5] = '{3, 3, 3};
    nxt[6] = '{4, 4, 6};
    m_st = 0;
    m_to = 0;

    bus.seconds_clk = 1'b0;
    drive(3'b000);
    reset = 1'b0;
    repeat (4) tick();
    check_val("reset state", int'(bus.state), 0);
    check_val("reset sw_run", int'(bus.sw_run), 0);
    check_val("reset sw_clear", int'(bus.sw_clear), 0);
    check_val("reset inc_h", int'(bus.inc_h), 0);
    check_val("reset inc_m", int'(bus.inc_m), 0);
    reset = 1'b1;
    tick();

    // Stopwatch path: start, hide, show, stop, clear.
    press(3'b010, 20, 1'b0);
    press(3'b010, 8, 1'b0);
    press(3'b100, 8, 1'b0);
    press(3'b010, 8, 1'b0);
    press(3'b010, 8, 1'b0);
    press(3'b001, 8, 1'b0);
    press(3'b100, 8, 1'b0);

    // Set modes with increments.
    press(3'b100, 8, 1'b0);
    repeat (3) press(3'b001, 6, 1'b0);
    press(3'b100, 8, 1'b0);
    press(3'b001, 6, 1'b0);
    press(3'b100, 8, 1'b0);

    // Glitches and bounce.
    glitch(3'b100, 3);
    glitch(3'b010, 1);
    press(3'b010, 5, 1'b1);
    press(3'b100, 6, 1'b0);

    // Timeout restarted by a press after the second tick.
    press(3'b100, 6, 1'b0);
    second();
    second();
    press(3'b001, 6, 1'b0);
    second();
    second();
    second();

    // M beats A in the same cycle.
    press(3'b010, 6, 1'b0);
    press(3'b110, 6, 1'b0);

    // Reset while running.
    press(3'b010, 6, 1'b0);
    press(3'b010, 6, 1'b0);
    reset = 1'b0;
    tick();
    check_val("reset in run state", int'(bus.state), 0);
    check_val("reset in run sw_run", int'(bus.sw_run), 0);
    reset = 1'b1;
    m_st = 0;
    m_to = 0;
    tick();

    // Press held across reset is discarded.
    snap();
    drive(3'b010);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (15) tick();
    drive(3'b000);
    repeat (12) tick();
    check_outputs("held across reset", 0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 22)      press(3'b100, int'($urandom_range(5, 12)), 1'b0);
      else if (r < 40) press(3'b010, int'($urandom_range(5, 12)), 1'b0);
      else if (r < 56) press(3'b001, int'($urandom_range(5, 12)), 1'b0);
      else if (r < 62) begin
        mask = 3'($urandom_range(3, 7));
        if (mask == 3'b100) mask = 3'b101;
        press(mask, int'($urandom_range(5, 12)), 1'b0);
      end else if (r < 69) begin
        mask = 3'b001 << $urandom_range(0, 2);
        glitch(mask, int'($urandom_range(1, 3)));
      end else if (r < 74) begin
        mask = 3'b001 << $urandom_range(0, 2);
        press(mask, int'($urandom_range(5, 9)), 1'b1);
      end else begin
        second();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
